// File: rtl/status_flag_unit.sv
// Two-stage {N,Z,C,V} status unit: capture register feeding a status register.
// Optional FLAG_BYPASS_EN exposes the value status_r takes at the next edge on status_next.
module status_flag_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic        s_bit,
  input  logic [3:0]  exe_cmd,
  input  logic [31:0] val1,
  input  logic [31:0] val2,
  input  logic        freeze,
  input  logic        flush,
  output logic [3:0]  status_r,
  output logic        pending,
  output logic [3:0]  status_next
);

  localparam logic [3:0] CMD_MOV = 4'b0001, CMD_MVN = 4'b1001, CMD_ADD = 4'b0010,
                         CMD_ADC = 4'b0011, CMD_SUB = 4'b0100, CMD_SBC = 4'b0101,
                         CMD_AND = 4'b0110, CMD_ORR = 4'b0111, CMD_EOR = 4'b1000;

  typedef struct packed {
    logic        vld;
    logic [3:0]  cmd;
    logic [31:0] a;
    logic [31:0] b;
  } cap_t;

  cap_t       cap_q, cap_d;
  logic [3:0] status_q, status_d;
  logic [3:0] flags;
  logic       cmd_ok, do_cap, do_wr;

  always_comb begin
    cmd_ok = 1'b0;
    case (exe_cmd)
      CMD_MOV, CMD_MVN, CMD_ADD, CMD_ADC, CMD_SUB,
      CMD_SBC, CMD_AND, CMD_ORR, CMD_EOR: cmd_ok = 1'b1;
      default:                            cmd_ok = 1'b0;
    endcase
  end

  assign do_cap = in_valid & s_bit & cmd_ok & ~freeze & ~flush;
  assign do_wr  = cap_q.vld & ~freeze & ~flush;

  // Subtraction is a + ~b + cin, so carry-out is the ARM "no borrow" C and one
  // overflow rule (equal operand signs, result sign flips) covers both directions.
  logic [32:0] sum;
  logic [31:0] opb, res;
  logic        cin, arith, ovf;

  always_comb begin
    arith = 1'b0;
    opb   = cap_q.b;
    cin   = 1'b0;
    res   = '0;
    flags = status_q;
    case (cap_q.cmd)
      CMD_ADD: begin arith = 1'b1; end
      CMD_ADC: begin arith = 1'b1; cin = status_q[1]; end
      CMD_SUB: begin arith = 1'b1; opb = ~cap_q.b; cin = 1'b1; end
      CMD_SBC: begin arith = 1'b1; opb = ~cap_q.b; cin = status_q[1]; end
      default: ;
    endcase
    sum = {1'b0, cap_q.a} + {1'b0, opb} + {32'b0, cin};
    ovf = (cap_q.a[31] == opb[31]) && (sum[31] != cap_q.a[31]);
    case (cap_q.cmd)
      CMD_ADD, CMD_ADC, CMD_SUB, CMD_SBC: res = sum[31:0];
      CMD_AND: res = cap_q.a & cap_q.b;
      CMD_ORR: res = cap_q.a | cap_q.b;
      CMD_EOR: res = cap_q.a ^ cap_q.b;
      CMD_MOV: res = cap_q.b;
      CMD_MVN: res = ~cap_q.b;
      default: res = '0;
    endcase
    if (arith) flags = {res[31], res == 32'd0, sum[32], ovf};
    else if (cap_q.cmd inside {CMD_AND, CMD_ORR, CMD_EOR, CMD_MOV, CMD_MVN})
      flags = {res[31], res == 32'd0, status_q[1:0]};
  end

  always_comb begin
    cap_d    = cap_q;
    status_d = status_q;
    if (do_wr) status_d = flags;
    if (flush)       cap_d.vld = 1'b0;
    else if (!freeze) begin
      cap_d.vld = do_cap;
      if (do_cap) begin
        cap_d.cmd = exe_cmd;
        cap_d.a   = val1;
        cap_d.b   = val2;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_q    <= '0;
      status_q <= 4'b0000;
    end else begin
      cap_q    <= cap_d;
      status_q <= status_d;
    end
  end

  assign status_r = status_q;
  assign pending  = cap_q.vld;

`ifdef FLAG_BYPASS_EN
  assign status_next = status_d;
`else
  assign status_next = status_q;
`endif

endmodule

// File: doc/status_flag_unit.md
STATUS_FLAG_UNIT -- requirements
Module: status_flag_unit

Interface
REQ-001 SHALL: clk  input  1  sole clock; all state updates on rising edge.
REQ-002 SHALL: rst_n  input  1  asynchronous, active-low reset.
REQ-003 SHALL: in_valid  input  1  execute-stage operation present this cycle.
REQ-004 SHALL: s_bit  input  1  operation requests a flag update; ignored when in_valid=0.
REQ-005 SHALL: exe_cmd  input  4  operation: 0001 MOV, 1001 MVN, 0010 ADD, 0011 ADC, 0100 SUB, 0101 SBC, 0110 AND, 0111 ORR, 1000 EOR; all other codes are a no-op.
REQ-006 SHALL: val1, val2  input  32 each  ALU operands (MOV/MVN use val2 only).
REQ-007 SHALL: freeze  input  1  pipeline stall.
REQ-008 SHALL: flush  input  1  discard the in-flight update.
REQ-009 SHALL: status_r  output  4  {N,Z,C,V}, bit3=N, bit2=Z, bit1=C, bit0=V; this is the bus the condition checker consumes.
REQ-010 SHALL: pending  output  1  a flag update is captured but not yet written.
REQ-011 SHALL: status_next  output  4  bypass view (see Configuration).

Function
REQ-012 SHALL: two stages: capture register (cap_valid, cmd, val1, val2) and status register.
REQ-013 SHALL: at an edge with in_valid=1, s_bit=1, a defined cmd, freeze=0 and flush=0, load the capture register and set cap_valid=1.
REQ-014 SHALL: at an edge with cap_valid=1, freeze=0 and flush=0, write the flags computed from the capture register into status_r; cap_valid clears unless a new capture occurs at the same edge.
REQ-015 SHALL: give a latency of exactly 2 edges, input to status_r; back-to-back updates SHALL sustain one per cycle.
REQ-016 SHALL: compute flags combinationally from the capture register and the current status_r, so ADC/SBC after an immediately preceding update use the already-written C.
REQ-017 SHALL: ADD/ADC: 33-bit sum val1+val2(+C); C=bit32; V=1 iff operand signs equal and result sign differs.
REQ-018 SHALL: SUB/SBC: val1-val2 (SBC additionally subtracts NOT C); C=1 iff no borrow; V=1 iff operand signs differ and result sign differs from val1.
REQ-019 SHALL: for AND/ORR/EOR/MOV/MVN (MVN uses ~val2), update N=result[31] and Z=(result==0) while holding C and V.
REQ-020 SHALL: pending = cap_valid.
REQ-021 SHALL: freeze=1 (flush=0) holds the capture register and status_r unchanged.
REQ-022 SHALL: flush=1 clears cap_valid with no status write, takes priority over freeze, and leaves status_r unchanged.
REQ-023 SHALL: not capture when in_valid=1 with s_bit=0 or an undefined cmd, so status_r holds.

Reset
REQ-024 SHALL: rst_n=0 immediately clear status_r to 4'b0000, cap_valid to 0 and the capture registers to 0, independent of clk.
REQ-025 SHALL: on reset asserted mid-operation, drop the captured update, so the first edge after release performs only a capture.

Configuration
REQ-026 SHALL: with FLAG_BYPASS_EN defined, status_next equal the value status_r will take at the next edge (computed flags when a write is due, otherwise status_r).
REQ-027 SHALL: without FLAG_BYPASS_EN, status_next be tied to status_r, so the port list is identical in both builds.

Verification
REQ-028 SHALL: cover this scenario: ADD with val1=0x7FFFFFFF, val2=1, s_bit=1 -> pending=1 after edge 1; status_r=1001 (N,V) after edge 2.
REQ-029 SHALL: cover this scenario: SUB 5-5, then back-to-back SBC 0-0 -> status_r=0110 after the first write, then 0110 again (C=1, no borrow).
REQ-030 SHALL: cover this scenario: status C=1, AND with val1=0, val2=0xFFFFFFFF -> status_r=0110 (Z set, C held).
REQ-031 SHALL: cover this scenario: capture ADD, assert freeze for 3 cycles, then release -> status_r unchanged and pending=1 while frozen; written on the first unfrozen edge.
REQ-032 SHALL: cover this scenario: capture SUB 1-2, assert flush and freeze together -> pending=0 and status_r unchanged.
REQ-033 SHALL: cover this scenario: capture update, pulse rst_n low between edges -> status_r=0000 and pending=0 immediately; with FLAG_BYPASS_EN, status_next=1001 one cycle before status_r for the REQ-028 stimulus.
